// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides and registered flags.
// MUL runs an iterative shift-add (one multiplier bit per cycle) and returns a 2*WIDTH product.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf
);

  localparam int CW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   y_reg, y_next;
  logic [WIDTH-1:0]   y_hi_reg, y_hi_next;
  logic [3:0]         flags_reg, flags_next;   // {zf, nf, cf, vf}

  logic               accept;
  logic [WIDTH-1:0]   rhs;
  logic [WIDTH:0]     add_sum, sub_diff, mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c, alu_v;

  assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  // INC/DEC reuse the ADD/SUB datapath with a constant 1 as the second operand.
  assign rhs      = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
  assign add_sum  = {1'b0, a} + {1'b0, rhs};
  assign sub_diff = {1'b0, a} - {1'b0, rhs};

  // Product register holds {partial_hi, remaining multiplier bits}; shift right each step.
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        alu_y = add_sum[MSB:0];
        alu_c = add_sum[WIDTH];
        alu_v = (a[MSB] == rhs[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        alu_y = sub_diff[MSB:0];
        alu_c = sub_diff[WIDTH];
        alu_v = (a[MSB] != rhs[MSB]) && (sub_diff[MSB] != a[MSB]);
      end
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mcand_next = mcand_reg;
    prod_next  = prod_reg;
    y_next     = y_reg;
    y_hi_next  = y_hi_reg;
    flags_next = flags_reg;
    case (state_reg)
      MUL: begin
        prod_next = prod_step;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          y_next     = prod_step[MSB:0];
          y_hi_next  = prod_step[2*WIDTH-1:WIDTH];
          flags_next = {prod_step[MSB:0] == '0, prod_step[MSB],
                        |prod_step[2*WIDTH-1:WIDTH], |prod_step[2*WIDTH-1:WIDTH]};
        end
      end
      default: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_next = MUL;
            cnt_next   = '0;
            mcand_next = a;
            prod_next  = {{WIDTH{1'b0}}, b};
          end else begin
            state_next = DONE;
            y_next     = alu_y;
            y_hi_next  = '0;
            flags_next = {alu_y == '0, alu_y[MSB], alu_c, alu_v};
          end
        end else if (state_reg == DONE && out_ready) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      prod_reg  <= '0;
      y_reg     <= '0;
      y_hi_reg  <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mcand_reg <= mcand_next;
      prod_reg  <= prod_next;
      y_reg     <= y_next;
      y_hi_reg  <= y_hi_next;
      flags_reg <= flags_next;
    end
  end

  assign y    = y_reg;
  assign y_hi = y_hi_reg;
  assign zf   = flags_reg[3];
  assign nf   = flags_reg[2];
  assign cf   = flags_reg[1];
  assign vf   = flags_reg[0];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=16 and a WIDTH=8 instance, directed cases plus random traffic
// checked by a queue-based scoreboard against an arithmetic reference model.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] y_hi;
    logic [3:0]  f;      // {zf, nf, cf, vf}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit rand_bp = 1'b0;

  logic        iv[2];
  logic [15:0] av[2];
  logic [15:0] bv[2];
  logic [2:0]  opv[2];
  logic        ordy[2];

  logic        ir16, ov16, zf16, nf16, cf16, vf16;
  logic [15:0] y16, yh16;
  logic        ir8, ov8, zf8, nf8, cf8, vf8;
  logic [7:0]  y8, yh8;

  exp_t q0[$];
  exp_t q1[$];

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir16),
    .a(av[0]), .b(bv[0]), .op(opv[0]), .out_valid(ov16), .out_ready(ordy[0]),
    .y(y16), .y_hi(yh16), .zf(zf16), .nf(nf16), .cf(cf16), .vf(vf16)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir8),
    .a(av[1][7:0]), .b(bv[1][7:0]), .op(opv[1]), .out_valid(ov8), .out_ready(ordy[1]),
    .y(y8), .y_hi(yh8), .zf(zf8), .nf(nf8), .cf(cf8), .vf(vf8)
  );

  function automatic longint sg(longint unsigned x, int w);
    return x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
  endfunction

  // Reference: plain integer arithmetic on the operands, then truncation to w bits.
  function automatic exp_t model(int w, logic [2:0] op, logic [15:0] ain, logic [15:0] bin);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned ua = {48'd0, ain} & m;
    longint unsigned ub = {48'd0, bin} & m;
    longint unsigned s2, full, r, hi;
    longint smax = (longint'(1) << (w - 1)) - 1;
    longint smin = -(longint'(1) << (w - 1));
    longint sr;
    bit c, v;
    exp_t e;
    r = 0; hi = 0; c = 0; v = 0; full = 0; sr = 0;
    s2 = (op == 3'd2 || op == 3'd3) ? 64'd1 : ub;
    case (op)
      3'd0, 3'd2: begin
        full = ua + s2; r = full & m; c = full > m;
        sr = sg(ua, w) + sg(s2, w); v = (sr > smax) || (sr < smin);
      end
      3'd1, 3'd3: begin
        r = (ua - s2) & m; c = ua < s2;
        sr = sg(ua, w) - sg(s2, w); v = (sr > smax) || (sr < smin);
      end
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: begin
        full = ua * ub; r = full & m; hi = full >> w; c = hi != 0; v = c;
      end
    endcase
    e.y = r[15:0];
    e.y_hi = hi[15:0];
    e.f = {r == 0, r[w-1], c, v};
    return e;
  endfunction

  function automatic logic get_ir(int sel);
    return (sel == 0) ? ir16 : ir8;
  endfunction

  function automatic logic get_ov(int sel);
    return (sel == 0) ? ov16 : ov8;
  endfunction

  function automatic exp_t observe(int sel);
    exp_t o;
    if (sel == 0) begin
      o.y = y16; o.y_hi = yh16; o.f = {zf16, nf16, cf16, vf16};
    end else begin
      o.y = {8'h00, y8}; o.y_hi = {8'h00, yh8}; o.f = {zf8, nf8, cf8, vf8};
    end
    return o;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rnd_operand(int w);
    logic [15:0] m = (w == 8) ? 16'h00FF : 16'hFFFF;
    logic [15:0] msb = (w == 8) ? 16'h0080 : 16'h8000;
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return m;
      2: return msb;
      3: return msb - 16'd1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // Present one op and hold it until the DUT accepts; push the expected response at accept.
  task automatic issue(input int sel, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int acc_cyc);
    int n = 0;
    bit done = 1'b0;
    exp_t e;
    iv[sel] = 1'b1; opv[sel] = op; av[sel] = a; bv[sel] = b;
    while (!done) begin
      @(negedge clk);
      if (get_ir(sel)) begin
        done = 1'b1;
        e = model(sel == 0 ? 16 : 8, op, a, b);
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end else if (++n > 100) begin
        done = 1'b1;
        check($sformatf("accept_timeout_dut%0d", sel), 0, 1);
      end
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    iv[sel] = 1'b0;
    av[sel] = 16'($urandom); bv[sel] = 16'($urandom); opv[sel] = 3'($urandom);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin tick(1); n++; end
    if (n >= 300) check("drain_timeout", 0, 1);
    tick(1);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) begin
      ordy[0] = ($urandom_range(0, 3) != 0);
      ordy[1] = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: whenever a result is presented it must equal the oldest pending expectation.
  initial begin
    exp_t o, e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (get_ov(s)) begin
          o = observe(s);
          vectors++;
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            miscompares++;
            $display("FAIL stale_out dut%0d: got y=%h y_hi=%h with nothing pending", s, o.y, o.y_hi);
          end else begin
            e = (s == 0) ? q0[0] : q1[0];
            if (o !== e) begin
              miscompares++;
              $display("FAIL result dut%0d: got y=%h y_hi=%h zncv=%b, expected y=%h y_hi=%h zncv=%b",
                       s, o.y, o.y_hi, o.f, e.y, e.y_hi, e.f);
            end
            if (ordy[s]) begin
              $display("dut%0d out y=%h y_hi=%h zncv=%b", s, o.y, o.y_hi, o.f);
              if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; av[s] = '0; bv[s] = '0; opv[s] = '0; ordy[s] = 1'b1;
    end
    rst_n = 1'b0;
    tick(2);
    check("rst_y16", y16, 0);        check("rst_yhi16", yh16, 0);
    check("rst_flags16", {zf16, nf16, cf16, vf16}, 0);
    check("rst_ov16", ov16, 0);      check("rst_ir16", ir16, 1);
    check("rst_y8", y8, 0);          check("rst_ov8", ov8, 0);
    check("rst_ir8", ir8, 1);
    rst_n = 1'b1;
    tick(1);

    // ADD overflow into the sign bit
    issue(0, 3'd0, 16'h7FFF, 16'h0001, c1);
    check("add_ov", ov16, 1);        check("add_y", y16, 16'h8000);
    check("add_nf", nf16, 1);        check("add_vf", vf16, 1);
    check("add_cf", cf16, 0);        check("add_zf", zf16, 0);
    check("add_yhi", yh16, 0);

    // Back-to-back SUB with out_ready held high
    issue(0, 3'd1, 16'd5, 16'd3, c1);
    check("sub1_y", y16, 2);         check("sub1_cf", cf16, 0);
    issue(0, 3'd1, 16'd3, 16'd5, c2);
    check("sub_b2b_cycle", c2, c1 + 1);
    check("sub2_y", y16, 16'hFFFE);  check("sub2_cf", cf16, 1);
    check("sub2_nf", nf16, 1);       check("sub2_vf", vf16, 0);
    drain();

    // MUL latency: result exactly 16 edges after accept, in_ready low meanwhile
    issue(0, 3'd7, 16'h0100, 16'h0100, c1);
    for (int j = 0; j <= 16; j++) begin
      check($sformatf("mul_ov_j%0d", j), ov16, (j == 16) ? 1 : 0);
      if (j < 16) begin
        check($sformatf("mul_ir_j%0d", j), ir16, 0);
        tick(1);
      end
    end
    check("mul_y", y16, 0);          check("mul_yhi", yh16, 1);
    check("mul_zf", zf16, 1);        check("mul_cf", cf16, 1);
    check("mul_vf", vf16, 1);
    issue(0, 3'd7, 16'd4, 16'd3, c1);
    drain();

    // Backpressure: result held stable while out_ready is low
    ordy[0] = 1'b0;
    issue(0, 3'd6, 16'b1010, 16'b0100, c1);
    for (int k = 0; k < 5; k++) begin
      check("bp_ov", ov16, 1);       check("bp_ir", ir16, 0);
      check("bp_y", y16, 16'b1110);
      tick(1);
    end
    ordy[0] = 1'b1;
    tick(1);
    check("bp_released", ov16, 0);
    drain();

    // Reset in the middle of a MUL: everything clears, nothing is ever emitted
    issue(0, 3'd7, 16'hBEEF, 16'h1234, c1);
    tick(7);
    rst_n = 1'b0;
    #1;
    check("mrst_y", y16, 0);         check("mrst_yhi", yh16, 0);
    check("mrst_flags", {zf16, nf16, cf16, vf16}, 0);
    check("mrst_ov", ov16, 0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_ir", ir16, 1);
    tick(20);
    check("mrst_no_result", ov16, 0);

    // WIDTH=8 boundaries
    issue(1, 3'd0, 16'h00FF, 16'h0001, c1);
    check("w8_add_y", y8, 0);        check("w8_add_zf", zf8, 1);
    check("w8_add_cf", cf8, 1);
    issue(1, 3'd7, 16'h00FF, 16'h00FF, c1);
    for (int j = 0; j <= 8; j++) begin
      check($sformatf("w8_mul_ov_j%0d", j), ov8, (j == 8) ? 1 : 0);
      if (j < 8) tick(1);
    end
    check("w8_mul_y", y8, 8'h01);    check("w8_mul_yhi", yh8, 8'hFE);
    issue(1, 3'd3, 16'h0000, 16'h0055, c1);
    check("w8_dec_y", y8, 8'hFF);    check("w8_dec_cf", cf8, 1);
    drain();

    // Random traffic on both instances with random backpressure
    rand_bp = 1'b1;
    fork
      for (int i = 0; i < 80; i++) begin
        int c;
        issue(0, 3'($urandom), rnd_operand(16), rnd_operand(16), c);
        tick($urandom_range(0, 2));
      end
      for (int i = 0; i < 80; i++) begin
        int c;
        issue(1, 3'($urandom), rnd_operand(8), rnd_operand(8), c);
        tick($urandom_range(0, 2));
      end
    join
    rand_bp = 1'b0;
    tick(1);
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    drain();
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
